out_alu_arbiter: RTL and testbench
==================================

OUT_ALU_ARBITER -- requirements
Module: out_alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, meaning result width of adder and multiplier.
REQ-002 SHALL have parameter ID_SIZE, default 8, meaning transaction ID width.
REQ-003 SHALL have parameter OPERATION_SIZE, default 2, meaning operation code width (01 = ADD, 10 = MUL).
REQ-004 SHALL have parameter FIFO_OUT_WIDTH, default DATA_SIZE+ID_SIZE+OPERATION_SIZE, meaning FIFO_OUT entry width.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, meaning synchronous active-low reset.
REQ-007 SHALL have port a_result_valid, input, 1 bit, meaning the adder presents a result.
REQ-008 SHALL have port a_result, input, DATA_SIZE bits, meaning the adder result.
REQ-009 SHALL have port a_result_id, input, ID_SIZE bits, meaning the adder result ID.
REQ-010 SHALL have port a_result_ready, output, 1 bit, meaning the add capture slot is empty.
REQ-011 SHALL have ports m_result_valid, m_result, m_result_id and m_result_ready, with the same directions and widths as the a_* ports, for the multiplier.
REQ-012 SHALL have port full_out, input, 1 bit, meaning FIFO_OUT is full.
REQ-013 SHALL have port w_en_out, output, 1 bit, meaning a single-cycle write strobe to FIFO_OUT.
REQ-014 SHALL have port fifo_out_data, output, FIFO_OUT_WIDTH bits, packed {result, id, op}, with op in bits [OPERATION_SIZE-1:0].
REQ-015 SHALL have ports add_cnt and mul_cnt, output, 8 bits each, meaning saturating counts of results written per source.
REQ-016 SHALL have port busy, output, 1 bit, meaning any slot is pending or w_en_out is high.

Function
REQ-017 SHALL keep one capture slot per source (data, id, pending flag); a_result_ready SHALL equal !a_pending, and m_result_ready SHALL equal !m_pending (combinational, no bypass).
REQ-018 SHALL load the slot and set pending at the edge where valid & ready; valid while not ready SHALL be ignored, and the source holds its data.
REQ-019 SHALL arbitrate at every edge: if full_out=0 and at least one slot is pending, grant one slot; otherwise grant none.
REQ-020 SHALL, when only one slot is pending, grant that slot; when both are pending, grant the source opposite to last_grant (round-robin).
REQ-021 SHALL, at a grant edge, register w_en_out=1 and fifo_out_data={slot data, slot id, op}, clear the granted pending flag, update last_grant, and increment the matching counter.
REQ-022 SHALL hold w_en_out high for exactly one cycle per grant; with no grant, w_en_out=0 and fifo_out_data SHALL hold its last value.
REQ-023 SHALL give a latency of handshake edge N -> w_en_out high in the cycle after edge N+1, when the grant is not stalled.
REQ-024 SHALL, while full_out=1, perform no grant, hold pending slots, and keep ready low for those slots, with no data loss.
REQ-025 SHALL allow a new capture into a slot at the edge after that slot's grant, since ready rises once pending clears.
REQ-026 SHALL allow capture into one slot and a grant from the other slot at the same edge.
REQ-027 SHALL saturate add_cnt and mul_cnt at 255, with no wrap-around.
REQ-028 SHALL drive busy as a_pending | m_pending | w_en_out.

Reset
REQ-029 SHALL, at the first edge with rst_n=0, clear both pending flags, w_en_out, fifo_out_data, add_cnt and mul_cnt to 0, and set last_grant=MUL so ADD wins the first tie.
REQ-030 SHALL, when reset occurs mid-operation, discard pending slots with no write; ready outputs SHALL read 1 from the cycle after the reset edge.

Verification
REQ-031 SHALL pass this scenario: single add, a_result=0x1234, id=0x05, full_out=0 -> one w_en_out pulse two edges later, fifo_out_data=0x1234_05_1, add_cnt=1.
REQ-032 SHALL pass this scenario: add (0x0001, id 1) and mul (0x0002, id 2) in the same cycle -> ADD written first, MUL on the next cycle; next simultaneous pair -> MUL first.
REQ-033 SHALL pass this scenario: full_out=1 for 5 cycles with both slots pending -> w_en_out=0, ready=0 throughout; after release -> 2 writes, in order, with data intact.
REQ-034 SHALL pass this scenario: 300 back-to-back adds -> add_cnt=255, mul_cnt=0.
REQ-035 SHALL pass this scenario: rst_n=0 for one edge while both slots are pending -> no write, busy=0, both ready=1, counters=0.
REQ-036 SHALL pass this scenario: a_result_valid held high continuously -> captures every 2 cycles, w_en_out on alternate cycles.

Source files
------------

// File: rtl/out_alu_arbiter.sv
// out_alu_arbiter: merges adder and multiplier results into FIFO_OUT.
// Round-robin arbitration between the two sources, with a capture slot per source.
module out_alu_arbiter #(
    parameter int DATA_SIZE      = 16,
    parameter int ID_SIZE        = 8,
    parameter int OPERATION_SIZE = 2,
    parameter int FIFO_OUT_WIDTH = DATA_SIZE + ID_SIZE + OPERATION_SIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      a_result_valid,
    input  logic [DATA_SIZE-1:0]      a_result,
    input  logic [ID_SIZE-1:0]        a_result_id,
    output logic                      a_result_ready,
    input  logic                      m_result_valid,
    input  logic [DATA_SIZE-1:0]      m_result,
    input  logic [ID_SIZE-1:0]        m_result_id,
    output logic                      m_result_ready,
    input  logic                      full_out,
    output logic                      w_en_out,
    output logic [FIFO_OUT_WIDTH-1:0] fifo_out_data,
    output logic [7:0]                add_cnt,
    output logic [7:0]                mul_cnt,
    output logic                      busy
);
    localparam logic [OPERATION_SIZE-1:0] OP_ADD = OPERATION_SIZE'(1);
    localparam logic [OPERATION_SIZE-1:0] OP_MUL = OPERATION_SIZE'(2);

    typedef enum logic {GRANT_ADD, GRANT_MUL} grant_t;

    logic                 a_pending, m_pending;
    logic [DATA_SIZE-1:0] a_data, m_data;
    logic [ID_SIZE-1:0]   a_id, m_id;
    grant_t               last_grant;
    logic                 can_grant, grant_add, grant_mul;

    assign a_result_ready = !a_pending;
    assign m_result_ready = !m_pending;
    assign busy           = a_pending | m_pending | w_en_out;

    // On a tie the source that did not win last time gets the slot.
    always_comb begin
        can_grant = !full_out && (a_pending || m_pending);
        grant_add = can_grant && a_pending && (!m_pending || last_grant == GRANT_MUL);
        grant_mul = can_grant && !grant_add;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_pending     <= 1'b0;
            m_pending     <= 1'b0;
            a_data        <= '0;
            a_id          <= '0;
            m_data        <= '0;
            m_id          <= '0;
            last_grant    <= GRANT_MUL;
            w_en_out      <= 1'b0;
            fifo_out_data <= '0;
            add_cnt       <= '0;
            mul_cnt       <= '0;
        end else begin
            w_en_out <= grant_add | grant_mul;
            if (a_pending) begin
                a_pending <= !grant_add;
            end else if (a_result_valid) begin
                a_pending <= 1'b1;
                a_data    <= a_result;
                a_id      <= a_result_id;
            end
            if (m_pending) begin
                m_pending <= !grant_mul;
            end else if (m_result_valid) begin
                m_pending <= 1'b1;
                m_data    <= m_result;
                m_id      <= m_result_id;
            end
            if (grant_add) begin
                fifo_out_data <= FIFO_OUT_WIDTH'({a_data, a_id, OP_ADD});
                last_grant    <= GRANT_ADD;
                if (add_cnt != 8'hFF)
                    add_cnt <= add_cnt + 8'd1;
            end
            if (grant_mul) begin
                fifo_out_data <= FIFO_OUT_WIDTH'({m_data, m_id, OP_MUL});
                last_grant    <= GRANT_MUL;
                if (mul_cnt != 8'hFF)
                    mul_cnt <= mul_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_out_alu_arbiter.sv
// tb_out_alu_arbiter: table vectors plus corner-case sequences, checked through an output scoreboard.
module tb_out_alu_arbiter;
    localparam int FW = 26;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_result_valid = 1'b0, m_result_valid = 1'b0;
    logic [15:0]   a_result = '0, m_result = '0;
    logic [7:0]    a_result_id = '0, m_result_id = '0;
    logic          a_result_ready, m_result_ready;
    logic          full_out = 1'b0;
    logic          w_en_out;
    logic [FW-1:0] fifo_out_data;
    logic [7:0]    add_cnt, mul_cnt;
    logic          busy;

    int n_checks = 0;
    int n_fail = 0;
    logic [FW-1:0] sb[$];

    typedef struct {
        bit          is_mul;
        logic [15:0] data;
        logic [7:0]  id;
        logic [FW-1:0] exp;
    } vec_t;
    vec_t vecs[6];

    out_alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_result_valid(a_result_valid), .a_result(a_result), .a_result_id(a_result_id), .a_result_ready(a_result_ready),
        .m_result_valid(m_result_valid), .m_result(m_result), .m_result_id(m_result_id), .m_result_ready(m_result_ready),
        .full_out(full_out), .w_en_out(w_en_out), .fifo_out_data(fifo_out_data),
        .add_cnt(add_cnt), .mul_cnt(mul_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] pack(input logic [15:0] d, input logic [7:0] id, input bit is_mul);
        return {d, id, is_mul ? 2'b10 : 2'b01};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && w_en_out) begin
            if (sb.size() == 0)
                check("unexpected_write", {38'd0, fifo_out_data}, 64'hDEAD_0000_0000_0000);
            else
                check("fifo_out_data", {38'd0, fifo_out_data}, {38'd0, sb.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_result_valid = 1'b0;
        m_result_valid = 1'b0;
        full_out = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50; k++) begin
            if (!busy) break;
            tick();
        end
        check("idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic drive_pair(input logic [15:0] ad, input logic [7:0] aid, input logic [15:0] md, input logic [7:0] mid);
        a_result_valid = 1'b1; a_result = ad; a_result_id = aid;
        m_result_valid = 1'b1; m_result = md; m_result_id = mid;
        tick();
        a_result_valid = 1'b0;
        m_result_valid = 1'b0;
    endtask

    task automatic single_add(input logic [15:0] d, input logic [7:0] id);
        a_result_valid = 1'b1; a_result = d; a_result_id = id;
        tick();
        a_result_valid = 1'b0;
        sb.push_back(pack(d, id, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_add, exp_mul;
        logic [15:0] d;
        vecs[0] = '{0, 16'h1234, 8'h05, pack(16'h1234, 8'h05, 1'b0)};
        vecs[1] = '{1, 16'h00FF, 8'h10, pack(16'h00FF, 8'h10, 1'b1)};
        vecs[2] = '{0, 16'hFFFF, 8'hFF, pack(16'hFFFF, 8'hFF, 1'b0)};
        vecs[3] = '{1, 16'hFFFF, 8'h00, pack(16'hFFFF, 8'h00, 1'b1)};
        vecs[4] = '{0, 16'h0000, 8'h80, pack(16'h0000, 8'h80, 1'b0)};
        vecs[5] = '{1, 16'hABCD, 8'h7E, pack(16'hABCD, 8'h7E, 1'b1)};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_w_en", {63'd0, w_en_out}, 64'd0);
        check("rst_data", {38'd0, fifo_out_data}, 64'd0);
        check("rst_a_ready", {63'd0, a_result_ready}, 64'd1);
        check("rst_m_ready", {63'd0, m_result_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_cnts", {48'd0, add_cnt, mul_cnt}, 64'd0);

        exp_add = 0;
        exp_mul = 0;
        foreach (vecs[i]) begin
            if (vecs[i].is_mul) begin
                m_result_valid = 1'b1; m_result = vecs[i].data; m_result_id = vecs[i].id;
                exp_mul++;
            end else begin
                a_result_valid = 1'b1; a_result = vecs[i].data; a_result_id = vecs[i].id;
                exp_add++;
            end
            tick();
            a_result_valid = 1'b0;
            m_result_valid = 1'b0;
            sb.push_back(vecs[i].exp);
            check("latency_pre", {63'd0, w_en_out}, 64'd0);
            tick();
            check("latency", {63'd0, w_en_out}, 64'd1);
            check("add_cnt", {56'd0, add_cnt}, 64'(exp_add));
            check("mul_cnt", {56'd0, mul_cnt}, 64'(exp_mul));
            wait_idle();
        end

        // Tie after a MUL grant: ADD first, then MUL.
        sb.push_back(pack(16'h0001, 8'h01, 1'b0));
        sb.push_back(pack(16'h0002, 8'h02, 1'b1));
        drive_pair(16'h0001, 8'h01, 16'h0002, 8'h02);
        wait_idle();
        // A lone ADD leaves ADD as last winner, so the next tie goes to MUL.
        single_add(16'h0003, 8'h03);
        wait_idle();
        sb.push_back(pack(16'h0005, 8'h05, 1'b1));
        sb.push_back(pack(16'h0004, 8'h04, 1'b0));
        drive_pair(16'h0004, 8'h04, 16'h0005, 8'h05);
        wait_idle();

        // Stall with both pending; last winner is ADD, so MUL drains first.
        full_out = 1'b1;
        drive_pair(16'h1111, 8'h11, 16'h2222, 8'h22);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_w_en", {63'd0, w_en_out}, 64'd0);
            check("stall_ready", {62'd0, a_result_ready, m_result_ready}, 64'd0);
        end
        sb.push_back(pack(16'h2222, 8'h22, 1'b1));
        sb.push_back(pack(16'h1111, 8'h11, 1'b0));
        full_out = 1'b0;
        wait_idle();
        check("sb_drained", 64'(sb.size()), 64'd0);

        // Reset with both slots pending must discard them.
        full_out = 1'b1;
        drive_pair(16'h3333, 8'h33, 16'h4444, 8'h44);
        check("busy_pending", {63'd0, busy}, 64'd1);
        do_reset();
        check("mrst_w_en", {63'd0, w_en_out}, 64'd0);
        check("mrst_busy", {63'd0, busy}, 64'd0);
        check("mrst_ready", {62'd0, a_result_ready, m_result_ready}, 64'd3);
        check("mrst_cnts", {48'd0, add_cnt, mul_cnt}, 64'd0);
        repeat (3) tick();
        check("mrst_no_write", {63'd0, busy}, 64'd0);

        // Valid held high: capture on even edges, write on odd edges.
        d = 16'hC000;
        a_result_valid = 1'b1; a_result = d; a_result_id = 8'h40;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("hold_w_en", {63'd0, w_en_out}, 64'(i % 2));
            check("hold_ready", {63'd0, a_result_ready}, 64'(i % 2));
            if (i % 2 == 0) begin
                sb.push_back(pack(a_result, a_result_id, 1'b0));
                d = d + 16'd1;
                a_result = d;
                a_result_id = a_result_id + 8'd1;
            end
        end
        a_result_valid = 1'b0;
        wait_idle();
        check("hold_add_cnt", {56'd0, add_cnt}, 64'd8);

        // Saturation over 300 back-to-back adds.
        do_reset();
        a_result_valid = 1'b1; a_result = 16'd0; a_result_id = 8'd0;
        for (int n = 0; n < 300; n++) begin
            tick();
            sb.push_back(pack(a_result, a_result_id, 1'b0));
            a_result = 16'(n + 1);
            a_result_id = 8'(n + 1);
            tick();
        end
        a_result_valid = 1'b0;
        wait_idle();
        check("sat_add_cnt", {56'd0, add_cnt}, 64'd255);
        check("sat_mul_cnt", {56'd0, mul_cnt}, 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
